rock_rate_scheduler: RTL and testbench

- Sequencer for the rocking amplitude/frequency datapath. Decides when to issue single-cycle frequency-up, frequency-down and amplitude-down commands to the A/F registers.
- Bases decisions on the cry-level sensor and on rocking-period completion pulses.
- Keeps 4-bit mirrors of A and F so it never commands past the datapath limits.
- Ensures at most one command per settle window.

---
 rtl/rock_pkg.sv | 9 +
 rtl/rock_sat_counter.sv | 24 ++
 rtl/rock_rate_scheduler.sv | 143 ++++++++++++++
 tb/tb_rock_rate_scheduler.sv | 113 +++++++++++
 4 files changed

// File: rtl/rock_pkg.sv
// rock_pkg: shared states, cry-level codes and code width for the rocking scheduler
package rock_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, EVAL = 2'd2, FINISH = 2'd3} rock_state_e;
   localparam logic [1:0] CRY_QUIET   = 2'd0;
   localparam logic [1:0] CRY_WHIMPER = 2'd1;
   localparam logic [1:0] CRY_CRY     = 2'd2;
   localparam logic [1:0] CRY_SCREAM  = 2'd3;
   localparam int AF_W = 4;
endpackage

// File: rtl/rock_sat_counter.sv
// rock_sat_counter: up/down mirror of a datapath code, clamped to [LO, HI]
module rock_sat_counter
   import rock_pkg::*;
#(
   parameter int LO   = 0,
   parameter int HI   = 15,
   parameter int INIT = 0
) (
   input  logic            FclkDff,
   input  logic            reset,
   input  logic            inc,
   input  logic            dec,
   output logic [AF_W-1:0] cnt
);
   localparam logic [AF_W-1:0] LO_C   = AF_W'(LO);
   localparam logic [AF_W-1:0] HI_C   = AF_W'(HI);
   localparam logic [AF_W-1:0] INIT_C = AF_W'(INIT);
   logic [AF_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = (inc && cnt_q < HI_C) ? cnt_q + 1'b1 : (dec && cnt_q > LO_C) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge FclkDff or posedge reset)
      if (reset) cnt_q <= INIT_C;
      else cnt_q <= cnt_d;
   assign cnt = cnt_q;
endmodule

// File: rtl/rock_rate_scheduler.sv
// rock_rate_scheduler: issues one-cycle A/F step commands per settle window from cry level.
// ROCK_ESCALATE_A_EN adds the a_up amplitude escalation output.
module rock_rate_scheduler
   import rock_pkg::*;
#(
   parameter int SETTLE_PERIODS = 4,
   parameter int CALM_EVALS     = 3,
   parameter int F_MIN          = 2,
   parameter int F_MAX          = 12,
`ifdef ROCK_ESCALATE_A_EN
   parameter int A_MAX          = 12,
`endif
   parameter int AF_INIT        = 5
) (
   input  logic            FclkDff,
   input  logic            reset,
   input  logic            enable,
   input  logic            cry_valid,
   input  logic [1:0]      cry_level,
   input  logic            cycle_done,
   output logic            f_up,
   output logic            f_down,
   output logic            a_down,
`ifdef ROCK_ESCALATE_A_EN
   output logic            a_up,
`endif
   output logic [AF_W-1:0] f_mirror,
   output logic [AF_W-1:0] a_mirror,
   output logic [1:0]      state,
   output logic            done
);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_PERIODS - 1);
   localparam logic [3:0] CALM_LAST   = 4'(CALM_EVALS - 1);
   localparam logic [AF_W-1:0] F_LO = AF_W'(F_MIN);
   localparam logic [AF_W-1:0] F_HI = AF_W'(F_MAX);
`ifdef ROCK_ESCALATE_A_EN
   localparam int A_TOP = A_MAX;
   localparam logic [AF_W-1:0] A_HI = AF_W'(A_MAX);
   logic a_up_q, a_up_d;
`else
   localparam int A_TOP = AF_INIT;
`endif
   rock_state_e state_q, state_d;
   logic [3:0] settle_q, settle_d, calm_q, calm_d;
   logic [1:0] last_level_q, last_level_d;
   logic f_up_q, f_up_d, f_down_q, f_down_d, a_down_q, a_down_d;
   always_comb begin
      state_d = state_q;
      settle_d = settle_q;
      calm_d = calm_q;
      last_level_d = cry_valid ? cry_level : last_level_q;
      f_up_d = 1'b0;
      f_down_d = 1'b0;
      a_down_d = 1'b0;
`ifdef ROCK_ESCALATE_A_EN
      a_up_d = 1'b0;
`endif
      case (state_q)
         IDLE: if (enable) begin
            state_d = SETTLE;
            settle_d = '0;
            calm_d = '0;
         end
         SETTLE: if (!enable) begin
            state_d = IDLE;
            settle_d = '0;
            calm_d = '0;
         end else if (cycle_done) begin
            state_d = settle_q == SETTLE_LAST ? EVAL : SETTLE;
            settle_d = settle_q == SETTLE_LAST ? 4'd0 : settle_q + 4'd1;
         end
         EVAL: if (!enable) begin
            state_d = IDLE;
            settle_d = '0;
            calm_d = '0;
         end else begin
            state_d = SETTLE;
            settle_d = '0;
            if (last_level_d >= CRY_CRY) begin
               calm_d = '0;
               f_up_d = f_mirror < F_HI;
`ifdef ROCK_ESCALATE_A_EN
               a_up_d = last_level_d == CRY_SCREAM && f_mirror == F_HI && a_mirror < A_HI;
`endif
            end else if (last_level_d == CRY_WHIMPER) calm_d = '0;
            else if (calm_q != CALM_LAST) calm_d = calm_q + 4'd1;
            else begin
               calm_d = '0;
               f_down_d = f_mirror > F_LO;
               a_down_d = f_mirror <= F_LO && a_mirror != '0;
               // last amplitude step ends the session
               if (a_down_d && a_mirror == AF_W'(1)) state_d = FINISH;
            end
         end
         FINISH: if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge FclkDff or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         settle_q <= '0;
         calm_q <= '0;
         last_level_q <= CRY_QUIET;
         f_up_q <= 1'b0;
         f_down_q <= 1'b0;
         a_down_q <= 1'b0;
`ifdef ROCK_ESCALATE_A_EN
         a_up_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         settle_q <= settle_d;
         calm_q <= calm_d;
         last_level_q <= last_level_d;
         f_up_q <= f_up_d;
         f_down_q <= f_down_d;
         a_down_q <= a_down_d;
`ifdef ROCK_ESCALATE_A_EN
         a_up_q <= a_up_d;
`endif
      end
   rock_sat_counter #(.LO(F_MIN), .HI(F_MAX), .INIT(AF_INIT)) u_f (
      .FclkDff(FclkDff), .reset(reset), .inc(f_up_d), .dec(f_down_d), .cnt(f_mirror)
   );
   rock_sat_counter #(.LO(0), .HI(A_TOP), .INIT(AF_INIT)) u_a (
      .FclkDff(FclkDff), .reset(reset),
`ifdef ROCK_ESCALATE_A_EN
      .inc(a_up_d),
`else
      .inc(1'b0),
`endif
      .dec(a_down_d), .cnt(a_mirror)
   );
   assign f_up = f_up_q;
   assign f_down = f_down_q;
   assign a_down = a_down_q;
`ifdef ROCK_ESCALATE_A_EN
   assign a_up = a_up_q;
`endif
   assign state = state_q;
   assign done = state_q == FINISH;
endmodule

// File: tb/tb_rock_rate_scheduler.sv
// tb_rock_rate_scheduler: directed checks of the rocking scheduler in its default build
module tb_rock_rate_scheduler;
   logic FclkDff = 1'b0, reset = 1'b1, enable = 1'b0, cry_valid = 1'b0, cycle_done = 1'b0;
   logic [1:0] cry_level = 2'd0;
   logic f_up, f_down, a_down, done;
   logic [3:0] f_mirror, a_mirror;
   logic [1:0] state;
   int passed = 0, total = 0;
   rock_rate_scheduler dut (
      .FclkDff(FclkDff), .reset(reset), .enable(enable), .cry_valid(cry_valid),
      .cry_level(cry_level), .cycle_done(cycle_done), .f_up(f_up), .f_down(f_down),
      .a_down(a_down), .f_mirror(f_mirror), .a_mirror(a_mirror), .state(state), .done(done)
   );
   always #5 FclkDff = ~FclkDff;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask
   // four rocking periods, then sample the registered EVAL outcome
   task automatic window(input string tag, input logic up, input logic dn, input logic ad,
                         input int f, input int a, input int st);
      for (int i = 0; i < 4; i++) begin
         @(negedge FclkDff) cycle_done = 1'b1;
         @(negedge FclkDff) cycle_done = 1'b0;
         @(negedge FclkDff);
      end
      check({tag, "_f_up"}, f_up, up);
      check({tag, "_f_down"}, f_down, dn);
      check({tag, "_a_down"}, a_down, ad);
      check({tag, "_f_mirror"}, f_mirror, f);
      check({tag, "_a_mirror"}, a_mirror, a);
      check({tag, "_state"}, state, st);
   endtask
   task automatic do_reset();
      @(negedge FclkDff) reset = 1'b1;
      enable = 1'b0;
      @(negedge FclkDff) reset = 1'b0;
   endtask
   initial begin
      cry_valid = 1'b1;
      cry_level = 2'd2;
      #12;
      check("rst_state", state, 0);
      check("rst_f_up", f_up, 0);
      check("rst_f_mirror", f_mirror, 5);
      check("rst_a_mirror", a_mirror, 5);
      check("rst_done", done, 0);
      @(negedge FclkDff) reset = 1'b0;
      enable = 1'b1;
      window("cry1", 1, 0, 0, 6, 5, 1);
      #2 reset = 1'b1;
      #1;
      check("midrst_f_up", f_up, 0);
      check("midrst_f_mirror", f_mirror, 5);
      check("midrst_state", state, 0);
      @(negedge FclkDff) reset = 1'b0;
      for (int f = 6; f <= 12; f++) window("ramp", 1, 0, 0, f, 5, 1);
      @(negedge FclkDff) check("ramp_pulse_len", f_up, 0);
      window("fmax", 0, 0, 0, 12, 5, 1);
      window("fmax2", 0, 0, 0, 12, 5, 1);
      do_reset();
      cry_level = 2'd0;
      enable = 1'b1;
      window("calm1", 0, 0, 0, 5, 5, 1);
      window("calm2", 0, 0, 0, 5, 5, 1);
      window("calm3", 0, 1, 0, 4, 5, 1);
      window("calm4", 0, 0, 0, 4, 5, 1);
      window("calm5", 0, 0, 0, 4, 5, 1);
      window("calm6", 0, 1, 0, 3, 5, 1);
      window("q1", 0, 0, 0, 3, 5, 1);
      window("q2", 0, 0, 0, 3, 5, 1);
      cry_level = 2'd1;
      window("whimper", 0, 0, 0, 3, 5, 1);
      cry_level = 2'd0;
      window("q3", 0, 0, 0, 3, 5, 1);
      window("q4", 0, 0, 0, 3, 5, 1);
      window("q5", 0, 1, 0, 2, 5, 1);
      for (int k = 1; k <= 15; k++)
         window("adown", 0, 0, k % 3 == 0, 2, 5 - k / 3, k == 15 ? 3 : 1);
      check("fin_done", done, 1);
      @(negedge FclkDff);
      check("fin_hold_state", state, 3);
      check("fin_hold_done", done, 1);
      check("fin_pulse_len", a_down, 0);
      enable = 1'b0;
      @(negedge FclkDff);
      check("fin_exit_state", state, 0);
      check("fin_exit_done", done, 0);
      do_reset();
      cry_level = 2'd2;
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge FclkDff) cycle_done = 1'b1;
         @(negedge FclkDff) cycle_done = 1'b0;
         @(negedge FclkDff);
      end
      @(negedge FclkDff) cycle_done = 1'b1;
      @(negedge FclkDff) cycle_done = 1'b0;
      check("drop_eval_state", state, 2);
      enable = 1'b0;
      @(negedge FclkDff);
      check("drop_state", state, 0);
      check("drop_f_up", f_up, 0);
      check("drop_f_mirror", f_mirror, 5);
      check("drop_a_mirror", a_mirror, 5);
      @(negedge FclkDff) cycle_done = 1'b1;
      @(negedge FclkDff) cycle_done = 1'b0;
      check("idle_ignore_state", state, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
